ripple_count_monitor: RTL

- Downstream consumer of the 4-bit asynchronous ripple up/down counter.
- Synchronises the counter's settling-prone q bus into the clk domain and filters ripple transients.
- Tracks the accepted count and reports each step, wrap-around, target match, and direction or illegal-jump errors.
- Output feeds the status/display logic that must never see intermediate ripple codes.

---
 rtl/ripple_count_monitor_pkg.sv | 14 +
 rtl/ripple_sync_filter.sv | 69 ++++++
 rtl/ripple_count_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ripple_count_monitor_pkg.sv
// Types and constants shared by the ripple counter monitor and its sub-blocks.
// The direction encoding matches the ripple counter's own mode input.
package ripple_count_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/ripple_sync_filter.sv
// Brings the asynchronous ripple counter bus into the clk domain and only
// reports a value once it has been seen unchanged for STABLE_CYCLES samples.
module ripple_sync_filter #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] candidate,
    output logic             accept
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_SAT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] primed;
    logic [WIDTH-1:0]       cand_q;
    logic [CW-1:0]          cnt_q;
    logic [WIDTH-1:0]       s_q;
    logic                   s_valid;
    logic                   load;
    logic                   hold;

    // primed walks a 1 through the synchroniser depth so the zeros left by
    // reset or restart are never mistaken for a real count.
    assign s_q     = sync_q[SYNC_STAGES-1];
    assign s_valid = primed[SYNC_STAGES-1];
    assign load    = s_valid && ((cnt_q == '0) || (s_q != cand_q));
    assign hold    = s_valid && !load && (cnt_q != CNT_SAT);
    assign accept  = (load && (STABLE_CYCLES == 1)) || (hold && (cnt_q == CNT_PRE));

    // Value being qualified this cycle, so a single-sample filter still
    // reports the value it is accepting rather than the previous one.
    assign candidate = load ? s_q : cand_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            primed <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q[0] <= q_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (restart) begin
                primed <= '0;
                cnt_q  <= '0;
            end else begin
                primed <= {primed[SYNC_STAGES-2:0], 1'b1};
                if (load) begin
                    cand_q <= s_q;
                    cnt_q  <= CW'(1);
                end else if (hold) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Tracks the filtered ripple counter value and flags steps, wraps, target hits
// and direction or illegal-jump errors for the status/display logic.
//
//  state    | meaning
//  ST_ACQ   | waiting for the first stable value; no events reported
//  ST_TRACK | count_out valid; each accepted change classified as step or jump
//  ST_ERR   | illegal jump seen; count_out follows silently until clr_err
module ripple_count_monitor
    import ripple_count_monitor_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] target,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count_out,
    output logic             count_valid,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             match_pulse,
    output logic             dir_err,
    output logic             jump_err
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] candidate;
    logic             accept;
    logic             restart;
    logic             is_up;
    logic             is_dn;
    logic [WIDTH-1:0] count_n;
    logic             valid_n;
    logic             step_n;
    logic             wrap_n;
    logic             match_n;
    logic             dir_n;
    logic             jump_n;

    ripple_sync_filter #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .q_in     (q_in),
        .candidate(candidate),
        .accept   (accept)
    );

    // Leaving ERR re-primes the filter so the current value is re-qualified
    // from scratch before tracking resumes.
    assign restart = (state == ST_ERR) && clr_err;
    assign is_up   = (candidate == count_out + WIDTH'(1));
    assign is_dn   = (candidate == count_out - WIDTH'(1));

    always_comb begin
        state_n = state;
        count_n = count_out;
        valid_n = count_valid;
        step_n  = 1'b0;
        wrap_n  = 1'b0;
        match_n = 1'b0;
        dir_n   = 1'b0;
        jump_n  = jump_err;
        case (state)
            ST_ACQ: begin
                if (accept) begin
                    count_n = candidate;
                    valid_n = 1'b1;
                    state_n = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (accept && (candidate != count_out)) begin
                    count_n = candidate;
                    if (is_up) begin
                        step_n  = 1'b1;
                        wrap_n  = (count_out == '1);
                        dir_n   = (mode_in != DIR_UP);
                        match_n = (candidate == target);
                    end else if (is_dn) begin
                        step_n  = 1'b1;
                        wrap_n  = (count_out == '0);
                        dir_n   = (mode_in != DIR_DN);
                        match_n = (candidate == target);
                    end else begin
                        jump_n  = 1'b1;
                        valid_n = 1'b0;
                        state_n = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    jump_n  = 1'b0;
                    state_n = ST_ACQ;
                end else if (accept) begin
                    count_n = candidate;
                end
            end
            default: begin
                state_n = ST_ACQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ACQ;
            count_out   <= '0;
            count_valid <= 1'b0;
            step_pulse  <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            dir_err     <= 1'b0;
            jump_err    <= 1'b0;
        end else begin
            state       <= state_n;
            count_out   <= count_n;
            count_valid <= valid_n;
            step_pulse  <= step_n;
            wrap_pulse  <= wrap_n;
            match_pulse <= match_n;
            dir_err     <= dir_n;
            jump_err    <= jump_n;
        end
    end

endmodule
